// File: rtl/fpalu_console.sv
// fpalu_console: board front-end for the FPALU.
// Synchronises and debounces the push-buttons, captures operands from the
// switches, runs a start/ready handshake with a bounded wait, latches the
// result and selects the word shown on the 7-segment decoders.
// Optional build macro: FPALU_CONSOLE_SHIFT_EN (load presses shift the
// operand left by SW_W and insert the switches in the LSBs).
`timescale 1ns/1ps
module fpalu_console #(
  parameter int DATA_W         = 32,
  parameter int SW_W           = 10,
  parameter int CTRL_W         = 5,
  parameter int DEB_CYCLES     = 500000,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              iclock,
  input  logic              ireset_n,
  input  logic [3:0]        ikey,
  input  logic [SW_W-1:0]   isw,
  input  logic [DATA_W-1:0] ialu_result,
  input  logic              ialu_ready,
  output logic [DATA_W-1:0] oalu_dataa,
  output logic [DATA_W-1:0] oalu_datab,
  output logic [CTRL_W-1:0] oalu_control,
  output logic              oalu_start,
  output logic [DATA_W-1:0] odisplay,
  output logic              obusy,
  output logic              otimeout,
  output logic [1:0]        ostate
);

  localparam int DEB_CW = $clog2(DEB_CYCLES + 1);
  localparam int TO_CW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [3:0]        key_meta_r, key_sync_r, key_deb_r, key_press_r;
  logic [DEB_CW-1:0] deb_cnt_r [4];
  logic [SW_W-1:0]   sw_meta_r, sw_sync_r;
  logic              start_prev_r;
  logic              start_edge_s;
  logic              to_done_s;
  logic [1:0]        state_r, state_nxt_s;
  logic [TO_CW-1:0]  to_cnt_r;
  logic [DATA_W-1:0] dataa_r, datab_r, result_r, display_r;
  logic [CTRL_W-1:0] control_r;
  logic              start_r, busy_r, timeout_r;

  assign start_edge_s = sw_sync_r[SW_W-1] & ~start_prev_r;
  assign to_done_s    = (to_cnt_r == TO_CW'(TIMEOUT_CYCLES - 1));

  // Two-stage synchronisers for keys and switches; keys idle released (high).
  always_ff @(posedge iclock or negedge ireset_n) begin
    if (!ireset_n) begin
      key_meta_r   <= 4'hF;
      key_sync_r   <= 4'hF;
      sw_meta_r    <= {SW_W{1'b0}};
      sw_sync_r    <= {SW_W{1'b0}};
      start_prev_r <= 1'b0;
    end else begin
      key_meta_r   <= ikey;
      key_sync_r   <= key_meta_r;
      sw_meta_r    <= isw;
      sw_sync_r    <= sw_meta_r;
      start_prev_r <= sw_sync_r[SW_W-1];
    end
  end

  // Per-key debounce: accept a new level after DEB_CYCLES differing samples; pulse on press.
  always_ff @(posedge iclock or negedge ireset_n) begin
    if (!ireset_n) begin
      key_deb_r   <= 4'hF;
      key_press_r <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        deb_cnt_r[i] <= {DEB_CW{1'b0}};
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (key_sync_r[i] == key_deb_r[i]) begin
          deb_cnt_r[i]   <= {DEB_CW{1'b0}};
          key_press_r[i] <= 1'b0;
        end else if (deb_cnt_r[i] == DEB_CW'(DEB_CYCLES - 1)) begin
          deb_cnt_r[i]   <= {DEB_CW{1'b0}};
          key_deb_r[i]   <= key_sync_r[i];
          key_press_r[i] <= ~key_sync_r[i];
        end else begin
          deb_cnt_r[i]   <= deb_cnt_r[i] + DEB_CW'(1);
          key_press_r[i] <= 1'b0;
        end
      end
    end
  end

  // Transaction FSM next state; ready takes priority over timeout in WAIT.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_edge_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (ialu_ready || to_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state, handshake outputs, timeout counter, op code and result capture.
  always_ff @(posedge iclock or negedge ireset_n) begin
    if (!ireset_n) begin
      state_r   <= ST_IDLE;
      start_r   <= 1'b0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
      to_cnt_r  <= {TO_CW{1'b0}};
      control_r <= {CTRL_W{1'b0}};
      result_r  <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      start_r <= (state_nxt_s == ST_ISSUE);
      busy_r  <= (state_nxt_s != ST_IDLE);
      if (state_r == ST_WAIT) begin
        to_cnt_r <= to_cnt_r + TO_CW'(1);
      end else begin
        to_cnt_r <= {TO_CW{1'b0}};
      end
      if ((state_r == ST_IDLE) && start_edge_s) begin
        control_r <= sw_sync_r[CTRL_W-1:0];
        timeout_r <= 1'b0;
      end else if ((state_r == ST_WAIT) && !ialu_ready && to_done_s) begin
        timeout_r <= 1'b1;
      end
      if ((state_r == ST_WAIT) && ialu_ready) begin
        result_r <= ialu_result;
      end
    end
  end

  // Operand capture on debounced load presses, accepted only while idle.
  always_ff @(posedge iclock or negedge ireset_n) begin
    if (!ireset_n) begin
      dataa_r <= {DATA_W{1'b0}};
      datab_r <= {DATA_W{1'b0}};
    end else if (state_r == ST_IDLE) begin
`ifdef FPALU_CONSOLE_SHIFT_EN
      if (key_press_r[0]) dataa_r <= {dataa_r[DATA_W-SW_W-1:0], sw_sync_r};
      if (key_press_r[1]) datab_r <= {datab_r[DATA_W-SW_W-1:0], sw_sync_r};
`else
      if (key_press_r[0]) dataa_r <= {sw_sync_r, {(DATA_W-SW_W){1'b0}}};
      if (key_press_r[1]) datab_r <= {sw_sync_r, {(DATA_W-SW_W){1'b0}}};
`endif
    end
  end

  // Display select: held KEY2 shows A (wins over KEY3), held KEY3 shows B, else result.
  always_ff @(posedge iclock or negedge ireset_n) begin
    if (!ireset_n) begin
      display_r <= {DATA_W{1'b0}};
    end else if (!key_deb_r[2]) begin
      display_r <= dataa_r;
    end else if (!key_deb_r[3]) begin
      display_r <= datab_r;
    end else begin
      display_r <= result_r;
    end
  end

  assign oalu_dataa   = dataa_r;
  assign oalu_datab   = datab_r;
  assign oalu_control = control_r;
  assign oalu_start   = start_r;
  assign odisplay     = display_r;
  assign obusy        = busy_r;
  assign otimeout     = timeout_r;
  assign ostate       = state_r;

endmodule

// File: tb/tb_fpalu_console.sv
// Directed bench for fpalu_console with DEB_CYCLES=4, TIMEOUT_CYCLES=16.
`timescale 1ns/1ps
module tb_fpalu_console;

  logic        clk;
  logic        rst_n;
  logic [3:0]  key;
  logic [9:0]  sw;
  logic [31:0] alu_result;
  logic        alu_ready;
  logic [31:0] dataa, datab, display;
  logic [4:0]  control;
  logic        start, busy, tmo;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  fpalu_console #(
    .DATA_W(32), .SW_W(10), .CTRL_W(5), .DEB_CYCLES(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .iclock(clk), .ireset_n(rst_n), .ikey(key), .isw(sw),
    .ialu_result(alu_result), .ialu_ready(alu_ready),
    .oalu_dataa(dataa), .oalu_datab(datab), .oalu_control(control),
    .oalu_start(start), .odisplay(display), .obusy(busy),
    .otimeout(tmo), .ostate(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  key;
    logic [9:0]  sw;
    int          cycles;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] exp_disp;
    logic [1:0]  exp_state;
    logic        exp_tmo;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dataa"},   dataa,   32'h0);
    chk({tag, "_datab"},   datab,   32'h0);
    chk({tag, "_control"}, {27'h0, control}, 32'h0);
    chk({tag, "_start"},   {31'h0, start},   32'h0);
    chk({tag, "_display"}, display, 32'h0);
    chk({tag, "_busy"},    {31'h0, busy},    32'h0);
    chk({tag, "_tmo"},     {31'h0, tmo},     32'h0);
    chk({tag, "_state"},   {30'h0, state},   32'h0);
  endtask

  task automatic press_a(input logic [9:0] v);
    sw  = v;
    key = 4'hE;
    cyc(10);
    key = 4'hF;
    cyc(10);
  endtask

  initial begin
    int start_cnt;
    int first_k;
    int wait_cnt;
    logic [4:0] ctl_at_start;
    logic busy_at_start;
    logic tmo_at_start;
    logic done;
    logic [31:0] exp_shift;

    vecs[0]  = '{4'hF, 10'h3FF, 25, 32'h0,        32'h0,        32'h0,        2'd0, 1'b1};
    vecs[1]  = '{4'hE, 10'h3FF, 10, 32'hFFC00000, 32'h0,        32'h0,        2'd0, 1'b1};
    vecs[2]  = '{4'hF, 10'h3FF, 10, 32'hFFC00000, 32'h0,        32'h0,        2'd0, 1'b1};
    vecs[3]  = '{4'hE, 10'h000,  2, 32'hFFC00000, 32'h0,        32'h0,        2'd0, 1'b1};
    vecs[4]  = '{4'hF, 10'h000, 10, 32'hFFC00000, 32'h0,        32'h0,        2'd0, 1'b1};
    vecs[5]  = '{4'hF, 10'h201, 25, 32'hFFC00000, 32'h0,        32'h0,        2'd0, 1'b1};
    vecs[6]  = '{4'hD, 10'h201, 10, 32'hFFC00000, 32'h80400000, 32'h0,        2'd0, 1'b1};
    vecs[7]  = '{4'hF, 10'h201, 10, 32'hFFC00000, 32'h80400000, 32'h0,        2'd0, 1'b1};
    vecs[8]  = '{4'hB, 10'h201, 10, 32'hFFC00000, 32'h80400000, 32'hFFC00000, 2'd0, 1'b1};
    vecs[9]  = '{4'h7, 10'h201, 10, 32'hFFC00000, 32'h80400000, 32'h80400000, 2'd0, 1'b1};
    vecs[10] = '{4'h3, 10'h201, 10, 32'hFFC00000, 32'h80400000, 32'hFFC00000, 2'd0, 1'b1};
    vecs[11] = '{4'hF, 10'h201, 10, 32'hFFC00000, 32'h80400000, 32'h0,        2'd0, 1'b1};

    // Reset state
    rst_n = 1'b0; key = 4'hF; sw = 10'h0; alu_result = 32'h0; alu_ready = 1'b0;
    cyc(3);
    chk_all_zero("rst_hold");
    rst_n = 1'b1;
    cyc(5);
    chk_all_zero("rst_rel");

    // Table: debounce, load, glitch rejection, display select
    for (int i = 0; i < 12; i++) begin
      key = vecs[i].key;
      sw  = vecs[i].sw;
      cyc(vecs[i].cycles);
      chk($sformatf("vec%0d_dataa", i),   dataa,   vecs[i].exp_a);
      chk($sformatf("vec%0d_datab", i),   datab,   vecs[i].exp_b);
      chk($sformatf("vec%0d_display", i), display, vecs[i].exp_disp);
      chk($sformatf("vec%0d_state", i),   {30'h0, state}, {30'h0, vecs[i].exp_state});
      chk($sformatf("vec%0d_tmo", i),     {31'h0, tmo},   {31'h0, vecs[i].exp_tmo});
    end

    // Start pulse timing and ready completion
    sw = 10'h000;
    cyc(5);
    sw = 10'h203;
    start_cnt = 0; first_k = 0;
    ctl_at_start = 5'h0; busy_at_start = 1'b0; tmo_at_start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (start) begin
        start_cnt++;
        if (first_k == 0) begin
          first_k = k;
          ctl_at_start = control;
          busy_at_start = busy;
          tmo_at_start = tmo;
        end
      end
    end
    chk("start_pulses", start_cnt, 32'd1);
    chk("start_edge_idx", first_k, 32'd3);
    chk("start_control", {27'h0, ctl_at_start}, 32'h3);
    chk("start_busy", {31'h0, busy_at_start}, 32'h1);
    chk("start_tmo_clr", {31'h0, tmo_at_start}, 32'h0);
    chk("wait_state", {30'h0, state}, 32'h2);
    alu_result = 32'h40490FDB;
    alu_ready = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    chk("ready_done", {31'h0, done}, 32'h1);
    alu_ready = 1'b0;
    @(negedge clk);
    chk("ready_display", display, 32'h40490FDB);
    chk("ready_state", {30'h0, state}, 32'h0);
    chk("ready_tmo", {31'h0, tmo}, 32'h0);
    alu_result = 32'hDEADBEEF;
    alu_ready = 1'b1;
    cyc(3);
    chk("idle_ready_ignored", display, 32'h40490FDB);
    chk("idle_ready_busy", {31'h0, busy}, 32'h0);
    alu_ready = 1'b0;

    // Timeout after 16 WAIT cycles, result unchanged
    sw = 10'h000;
    cyc(5);
    sw = 10'h205;
    wait_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (state == 2'd2) wait_cnt++;
    end
    chk("to_wait_cycles", wait_cnt, 32'd16);
    chk("to_tmo", {31'h0, tmo}, 32'h1);
    chk("to_state", {30'h0, state}, 32'h0);
    chk("to_control", {27'h0, control}, 32'h5);
    chk("to_display", display, 32'h40490FDB);

    // Next start clears the timeout flag; then reset mid-WAIT
    sw = 10'h000;
    cyc(3);
    sw = 10'h200;
    cyc(3);
    chk("restart_start", {31'h0, start}, 32'h1);
    chk("restart_tmo_clr", {31'h0, tmo}, 32'h0);
    cyc(4);
    chk("midwait_state", {30'h0, state}, 32'h2);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    sw = 10'h000;
    cyc(3);
    rst_n = 1'b1;
    start_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (start) start_cnt++;
    end
    chk("rst_no_reissue", start_cnt, 32'd0);
    chk_all_zero("rst_after");

    // Multi-press operand entry
    press_a(10'h001);
    press_a(10'h002);
    press_a(10'h003);
`ifdef FPALU_CONSOLE_SHIFT_EN
    exp_shift = 32'h00100803;
`else
    exp_shift = 32'h00C00000;
`endif
    chk("multi_press_dataa", dataa, exp_shift);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
